moving_window_sum: RTL and testbench
====================================

Name: moving_window_sum

Overview:
- Streaming sliding-window accumulator for complex I/Q samples in the CSI extraction datapath.
- Sits downstream of the sample delay line, on the read side. It keeps its own 2^WINDOW_SHIFT-deep ring of past samples.
- On every accepted sample it adds the new sample, subtracts the sample leaving the window, and emits the registered window sum.
- Feeds the correlation/energy normalisation stages used for packet detection.

Parameters:
- SAMPLE_WIDTH, 16, width of each signed I and Q component.
- WINDOW_SHIFT, 4, log2 of window length; window N = 2^WINDOW_SHIFT samples; minimum 1.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- clear_in  input  1  synchronous flush: empty the window and restart filling.
- data_in  input  2*SAMPLE_WIDTH  {I[2W-1:W], Q[W-1:0]}, two's complement.
- data_in_valid  input  1  qualifies data_in; one sample per cycle when high.
- sum_out  output  2*(SAMPLE_WIDTH+WINDOW_SHIFT)  {I_sum, Q_sum}, signed, registered.
- delayed_out  output  2*SAMPLE_WIDTH  sample that just left the window (N samples old), registered.
- sum_out_valid  output  1  one-cycle strobe that qualifies sum_out and delayed_out.
- filling_out  output  1  high while fewer than N samples are held since reset/clear.

Behaviour:
- Reset, asynchronous on rst_n_in low:
  - All ring entries are 0; ring pointer is 0; fill counter is 0.
  - Both accumulators, sum_out and delayed_out are 0.
  - sum_out_valid is 0. filling_out is 1. State is FILL.
  - Release is synchronous to clk_in; the first edge after release may accept a sample.
- States:
  - FILL: fill counter < N.
  - RUN: window full.
  - FILL -> RUN on the edge that accepts the Nth sample.
  - RUN -> FILL only on clear_in.
  - There is no other transition.
- Accept cycle (data_in_valid=1, clear_in=0), all registers updated on that edge:
  - acc_I <= acc_I + sext(I_in) - sext(ring[ptr].I); same arithmetic for Q.
  - delayed_out <= ring[ptr]; ring[ptr] <= data_in; ptr <= ptr+1, wrapping mod N.
  - sum_out <= the new accumulator values.
  - sum_out_valid <= 1 if in RUN, or if in FILL with fill counter = N-1; else 0.
- Latency: sum_out is valid one cycle after the accepting edge. The strobe first asserts for the Nth accepted sample, then for every accepted sample thereafter.
- Idle cycle (data_in_valid=0): accumulators, ring, pointer, sum_out and delayed_out hold; sum_out_valid <= 0.
- Arithmetic:
  - Accumulators are SAMPLE_WIDTH+WINDOW_SHIFT bits signed; operands are sign-extended.
  - The sum of N samples always fits the accumulator width, so there is no saturation and no overflow flag.
  - Intermediate add/subtract uses one extra guard bit, truncated after the subtract.
- Fill semantics:
  - During FILL the ring holds zeros in unwritten slots, so the subtracted value is 0.
  - The accumulator therefore equals the partial sum of the samples received so far. It is internal only; no strobe is issued.
- filling_out is 1 in FILL and 0 in RUN. It is registered and updates on the same edge as the state.
- clear_in = 1, synchronous:
  - Ring entries, pointer, fill counter and accumulators go to 0; state goes to FILL.
  - sum_out_valid <= 0; sum_out and delayed_out hold their last values.
- clear_in together with data_in_valid: clear wins and the sample is discarded. The next valid sample is sample 1 of the new window.
- Wrap-around: the pointer wraps from N-1 to 0 with no bubble. Back-to-back valid samples sustain one output per cycle indefinitely.
- Reset asserted mid-stream: everything is cleared immediately, asynchronously. An in-flight strobe is cancelled.

Test Plan:
- Fill and strobe: reset, then 16 back-to-back samples I=1, Q=-1.
  - sum_out_valid is first high in the cycle after the 16th sample, with I_sum=16, Q_sum=-16 and delayed_out=0.
  - filling_out falls on that same edge.
- Sliding: continue with 16 samples I=3, Q=2.
  - I_sum steps 18, 20, ... 48 and Q_sum steps -13, -10, ... 32.
  - delayed_out = {1,-1} for each of those samples.
- Extremes: 32 samples of I=-32768, Q=32767.
  - Once full, I_sum = -524288 and Q_sum = 524272 exactly, with no wrap; the output width is 20 bits.
- Gapped input: valid asserted every third cycle with a ramp I=k, Q=0.
  - Outputs hold during gaps and the strobe is one cycle per accepted sample.
  - I_sum = sum of the last 16 k values.
- Clear mid-run: assert clear_in together with data_in_valid while in RUN.
  - The sample is dropped; the strobe stays low for the next 15 accepted samples and reasserts on the 16th.
  - The new sum counts only post-clear data.
- Async reset: drop rst_n_in between clock edges while in RUN.
  - sum_out_valid = 0, sum_out = 0 and filling_out = 1 immediately, before the next edge.
  - After release, refill behaves as in the first scenario.

Source files
------------

// File: rtl/moving_window_sum.sv
// Sliding-window I/Q accumulator: running sum over the last 2^WINDOW_SHIFT accepted samples,
// with an explicit ring so the leaving sample can be subtracted and reported.
module moving_window_sum #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int WINDOW_SHIFT = 4
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic                                   clear_in,
  input  logic [2*SAMPLE_WIDTH-1:0]              data_in,
  input  logic                                   data_in_valid,
  output logic [2*(SAMPLE_WIDTH+WINDOW_SHIFT)-1:0] sum_out,
  output logic [2*SAMPLE_WIDTH-1:0]              delayed_out,
  output logic                                   sum_out_valid,
  output logic                                   filling_out
);

  localparam int N  = 1 << WINDOW_SHIFT;
  localparam int SW = SAMPLE_WIDTH;
  localparam int AW = SAMPLE_WIDTH + WINDOW_SHIFT;
  localparam int DW = 2 * SAMPLE_WIDTH;

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [WINDOW_SHIFT-1:0] r_ptr;
  logic [WINDOW_SHIFT-1:0] r_fill_cnt;
  logic signed [AW-1:0]    r_acc_i;
  logic signed [AW-1:0]    r_acc_q;
  logic [2*AW-1:0]         r_sum;
  logic [DW-1:0]           r_delayed;
  logic                    r_valid;

  logic [DW-1:0]           w_ring [N];
  logic [DW-1:0]           w_old;
  logic                    w_accept;
  logic                    w_last_fill;
  logic                    w_filling;
  logic                    w_strobe;
  logic [AW:0]             w_acc_i_ext;
  logic [AW:0]             w_acc_q_ext;
  logic [AW-1:0]           w_acc_i_next;
  logic [AW-1:0]           w_acc_q_next;
  logic                    w_unused_guard;

  assign w_accept    = data_in_valid & ~clear_in;
  assign w_last_fill = (r_fill_cnt == {WINDOW_SHIFT{1'b1}});
  assign w_old       = w_ring[r_ptr];

  // Each slot is an individual register so clear can zero the whole window in one cycle.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic [DW-1:0] r_slot;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
        r_slot <= '0;
      else if (clear_in)
        r_slot <= '0;
      else if (w_accept && (r_ptr == WINDOW_SHIFT'(gi)))
        r_slot <= data_in;
    end
    assign w_ring[gi] = r_slot;
  end

  // One guard bit keeps add-then-subtract exact before truncating back to AW.
  assign w_acc_i_ext = {r_acc_i[AW-1], r_acc_i}
                     + {{(AW+1-SW){data_in[DW-1]}}, data_in[DW-1:SW]}
                     - {{(AW+1-SW){w_old[DW-1]}}, w_old[DW-1:SW]};
  assign w_acc_q_ext = {r_acc_q[AW-1], r_acc_q}
                     + {{(AW+1-SW){data_in[SW-1]}}, data_in[SW-1:0]}
                     - {{(AW+1-SW){w_old[SW-1]}}, w_old[SW-1:0]};
  assign w_acc_i_next   = w_acc_i_ext[AW-1:0];
  assign w_acc_q_next   = w_acc_q_ext[AW-1:0];
  assign w_unused_guard = w_acc_i_ext[AW] ^ w_acc_q_ext[AW];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      r_state <= S_FILL;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:  if (clear_in) w_state_next = S_FILL;
               else if (w_accept && w_last_fill) w_state_next = S_RUN;
      S_RUN:   if (clear_in) w_state_next = S_FILL;
      default: w_state_next = S_FILL;
    endcase
  end

  always_comb begin
    w_filling = (r_state == S_FILL);
    w_strobe  = w_accept && ((r_state == S_RUN) || w_last_fill);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ptr      <= '0;
      r_fill_cnt <= '0;
      r_acc_i    <= '0;
      r_acc_q    <= '0;
      r_sum      <= '0;
      r_delayed  <= '0;
      r_valid    <= 1'b0;
    end else if (clear_in) begin
      r_ptr      <= '0;
      r_fill_cnt <= '0;
      r_acc_i    <= '0;
      r_acc_q    <= '0;
      r_valid    <= 1'b0;
    end else if (w_accept) begin
      r_acc_i   <= w_acc_i_next;
      r_acc_q   <= w_acc_q_next;
      r_sum     <= {w_acc_i_next, w_acc_q_next};
      r_delayed <= w_old;
      r_ptr     <= r_ptr + 1'b1;
      if (r_state == S_FILL)
        r_fill_cnt <= r_fill_cnt + 1'b1;
      r_valid   <= w_strobe;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign sum_out       = r_sum;
  assign delayed_out   = r_delayed;
  assign sum_out_valid = r_valid;
  assign filling_out   = w_filling;

endmodule

// File: tb/tb_moving_window_sum.sv
// Directed + random stimulus for moving_window_sum, checked against a queue-based
// window model that recomputes each sum from the retained samples.
module tb_moving_window_sum;

  localparam int SW = 16;
  localparam int WS = 4;
  localparam int N  = 1 << WS;
  localparam int AW = SW + WS;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic              clear_in = 1'b0;
  logic [2*SW-1:0]   data_in = '0;
  logic              data_in_valid = 1'b0;
  logic [2*AW-1:0]   sum_out;
  logic [2*SW-1:0]   delayed_out;
  logic              sum_out_valid;
  logic              filling_out;

  int total = 0;
  int bad   = 0;

  int hist_i[$];
  int hist_q[$];
  logic [2*AW-1:0] exp_sum = '0;
  logic [2*SW-1:0] exp_delayed = '0;
  logic            exp_valid = 1'b0;

  moving_window_sum #(.SAMPLE_WIDTH(SW), .WINDOW_SHIFT(WS)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .clear_in      (clear_in),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .sum_out       (sum_out),
    .delayed_out   (delayed_out),
    .sum_out_valid (sum_out_valid),
    .filling_out   (filling_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2*AW-1:0] pack_sum(input int si, input int sq);
    logic [31:0] vi;
    logic [31:0] vq;
    vi = si;
    vq = sq;
    return {vi[AW-1:0], vq[AW-1:0]};
  endfunction

  // One clock: drive, clock, update model, compare everything visible.
  task automatic step(input bit v, input bit c, input int i, input int q);
    logic [31:0] vi;
    logic [31:0] vq;
    int si;
    int sq;
    int lo;
    vi = i;
    vq = q;
    @(negedge clk_in);
    data_in_valid = v;
    clear_in      = c;
    data_in       = {vi[SW-1:0], vq[SW-1:0]};
    @(posedge clk_in);
    #1;
    if (c) begin
      hist_i.delete();
      hist_q.delete();
      exp_valid = 1'b0;
    end else if (v) begin
      hist_i.push_back(i);
      hist_q.push_back(q);
      while (hist_i.size() > N + 1) begin
        void'(hist_i.pop_front());
        void'(hist_q.pop_front());
      end
      si = 0;
      sq = 0;
      lo = (hist_i.size() > N) ? hist_i.size() - N : 0;
      for (int k = lo; k < hist_i.size(); k++) begin
        si += hist_i[k];
        sq += hist_q[k];
      end
      exp_sum = pack_sum(si, sq);
      if (hist_i.size() == N + 1) begin
        vi = hist_i[0];
        vq = hist_q[0];
        exp_delayed = {vi[SW-1:0], vq[SW-1:0]};
      end else begin
        exp_delayed = '0;
      end
      exp_valid = (hist_i.size() >= N);
    end else begin
      exp_valid = 1'b0;
    end
    data_in_valid = 1'b0;
    clear_in      = 1'b0;
    check("valid",   64'(sum_out_valid), 64'(exp_valid));
    check("filling", 64'(filling_out),   64'(hist_i.size() < N));
    check("sum",     64'(sum_out),       64'(exp_sum));
    check("delayed", 64'(delayed_out),   64'(exp_delayed));
    $display("t=%0t v=%0b c=%0b in=(%0d,%0d) sum=%h dly=%h sv=%0b fill=%0b",
             $time, v, c, i, q, sum_out, delayed_out, sum_out_valid, filling_out);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_valid",   64'(sum_out_valid), 64'(0));
    check("rst_filling", 64'(filling_out),   64'(1));
    check("rst_sum",     64'(sum_out),       64'(0));
    check("rst_delayed", 64'(delayed_out),   64'(0));
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Fill and strobe
    for (int k = 0; k < N; k++) step(1, 0, 1, -1);
    check("fill_sum16", 64'(sum_out), 64'(pack_sum(16, -16)));

    // Sliding
    for (int k = 0; k < N; k++) step(1, 0, 3, 2);
    check("slide_sum", 64'(sum_out), 64'(pack_sum(48, 32)));

    // Extremes
    for (int k = 0; k < 2 * N; k++) step(1, 0, -32768, 32767);
    check("extreme_sum", 64'(sum_out), 64'(pack_sum(-524288, 524272)));

    // Gapped ramp
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, k, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    check("gap_sum", 64'(sum_out), 64'(pack_sum(200, 0)));

    // Clear together with valid while running
    step(1, 1, 1234, -1234);
    for (int k = 0; k < N + 4; k++) step(1, 0, rnd_sample(), rnd_sample());

    // Asynchronous reset between edges, right after a strobe
    step(1, 0, 77, -77);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("arst_valid",   64'(sum_out_valid), 64'(0));
    check("arst_sum",     64'(sum_out),       64'(0));
    check("arst_filling", 64'(filling_out),   64'(1));
    hist_i.delete();
    hist_q.delete();
    exp_sum     = '0;
    exp_delayed = '0;
    exp_valid   = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int k = 0; k < N; k++) step(1, 0, 1, -1);
    check("refill_sum16", 64'(sum_out), 64'(pack_sum(16, -16)));

    // Random mixed traffic with occasional clears
    for (int k = 0; k < 200; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, rnd_sample(), rnd_sample());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
